// File: rtl/banco_registros_dual_if.sv
// Write-back, issue and read-port bundle between the two-issue pipeline and
// the dual-write register bank.
interface banco_registros_dual_if #(
  parameter int unsigned DW = 32
);
  logic          REG_WR1;
  logic          REG_WR2;
  logic [4:0]    DIR_WRA1;
  logic [4:0]    DIR_WRA2;
  logic [DW-1:0] DI_banco1;
  logic [DW-1:0] DI_banco2;
  logic [DW-1:0] DO_D1;
  logic [DW-1:0] DO_D2;
  logic          MEM_SEL1;
  logic          MEM_SEL2;
  logic          ISS1;
  logic          ISS2;
  logic [4:0]    ISS_DIR1;
  logic [4:0]    ISS_DIR2;
  logic [4:0]    RA1;
  logic [4:0]    RB1;
  logic [4:0]    RA2;
  logic [4:0]    RB2;
  logic [DW-1:0] QA1;
  logic [DW-1:0] QB1;
  logic [DW-1:0] QA2;
  logic [DW-1:0] QB2;
  logic          STALL;
  logic [31:0]   PEND;

  modport master (
    output REG_WR1, REG_WR2, DIR_WRA1, DIR_WRA2, DI_banco1, DI_banco2,
           DO_D1, DO_D2, MEM_SEL1, MEM_SEL2, ISS1, ISS2, ISS_DIR1, ISS_DIR2,
           RA1, RB1, RA2, RB2,
    input  QA1, QB1, QA2, QB2, STALL, PEND
  );

  modport slave (
    input  REG_WR1, REG_WR2, DIR_WRA1, DIR_WRA2, DI_banco1, DI_banco2,
           DO_D1, DO_D2, MEM_SEL1, MEM_SEL2, ISS1, ISS2, ISS_DIR1, ISS_DIR2,
           RA1, RB1, RA2, RB2,
    output QA1, QB1, QA2, QB2, STALL, PEND
  );
endinterface

// File: rtl/banco_registros_dual.sv
// Dual-write-port register bank with write-back select, bypassed read ports
// and a pending-destination scoreboard driving the decode stall.
module banco_registros_dual #(
  parameter int unsigned NREG = 32,
  parameter int unsigned DW   = 32
) (
  input logic                  reloj,
  input logic                  resetM,
  banco_registros_dual_if.slave bus
);
  localparam int unsigned AW = 5;

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  logic [DW-1:0] wd1;
  logic [DW-1:0] wd2;
  logic          we1;
  logic          we2;
  logic [AW-1:0] wa1;
  logic [AW-1:0] wa2;

  assign wd1 = bus.MEM_SEL1 ? bus.DO_D1 : bus.DI_banco1;
  assign wd2 = bus.MEM_SEL2 ? bus.DO_D2 : bus.DI_banco2;
  assign wa1 = bus.DIR_WRA1;
  assign wa2 = bus.DIR_WRA2;
  assign we1 = !bus.REG_WR1 && (wa1 != '0);
  assign we2 = !bus.REG_WR2 && (wa2 != '0);

  // Port 2 carries the younger instruction, so it overrides port 1 everywhere.
  function automatic logic [DW-1:0] rd_byp(input logic [AW-1:0] ra);
    if (ra == '0)              return '0;
    else if (we2 && wa2 == ra) return wd2;
    else if (we1 && wa1 == ra) return wd1;
    else                       return regs_q[ra];
  endfunction

  function automatic logic blocked(input logic [AW-1:0] ra);
    return (ra != '0) && pend_q[ra] && !(we1 && wa1 == ra) && !(we2 && wa2 == ra);
  endfunction

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (we2 && wa2 == AW'(i))      regs_d[i] = wd2;
      else if (we1 && wa1 == AW'(i)) regs_d[i] = wd1;
      // A fresh issue to the same destination outranks the retiring producer.
      if ((bus.ISS1 && bus.ISS_DIR1 == AW'(i)) || (bus.ISS2 && bus.ISS_DIR2 == AW'(i)))
        pend_d[i] = 1'b1;
      else if ((we1 && wa1 == AW'(i)) || (we2 && wa2 == AW'(i)))
        pend_d[i] = 1'b0;
    end
    regs_d[0] = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  assign bus.QA1   = rd_byp(bus.RA1);
  assign bus.QB1   = rd_byp(bus.RB1);
  assign bus.QA2   = rd_byp(bus.RA2);
  assign bus.QB2   = rd_byp(bus.RB2);
  assign bus.STALL = blocked(bus.RA1) || blocked(bus.RB1) ||
                     blocked(bus.RA2) || blocked(bus.RB2);
  assign bus.PEND  = 32'(pend_q);

endmodule

// File: tb/tb_banco_registros_dual.sv
// Directed and randomized check of banco_registros_dual against an
// architectural register/scoreboard model.
module tb_banco_registros_dual;
  logic reloj;
  logic resetM;

  banco_registros_dual_if bus ();

  banco_registros_dual dut (
    .reloj  (reloj),
    .resetM (resetM),
    .bus    (bus)
  );

  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int p);
    if (p == 1) return bus.MEM_SEL1 ? bus.DO_D1 : bus.DI_banco1;
    return bus.MEM_SEL2 ? bus.DO_D2 : bus.DI_banco2;
  endfunction

  function automatic logic wr_to(input int p, input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (p == 1) return !bus.REG_WR1 && bus.DIR_WRA1 == r;
    return !bus.REG_WR2 && bus.DIR_WRA2 == r;
  endfunction

  // Architectural view of a read: zero register, then youngest write, then storage.
  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0)   return 32'h0;
    if (wr_to(2, r)) return wd(2);
    if (wr_to(1, r)) return wd(1);
    return m_regs[r];
  endfunction

  function automatic logic m_waits(input logic [4:0] r);
    return r != 5'd0 && m_pend[r] && !wr_to(1, r) && !wr_to(2, r);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_pend = 32'h0;
  endtask

  task automatic m_update();
    logic [4:0] a1;
    logic [4:0] a2;
    a1 = bus.DIR_WRA1;
    a2 = bus.DIR_WRA2;
    if (resetM) return;
    if (wr_to(1, a1)) begin m_regs[a1] = wd(1); m_pend[a1] = 1'b0; end
    if (wr_to(2, a2)) begin m_regs[a2] = wd(2); m_pend[a2] = 1'b0; end
    if (bus.ISS1) m_pend[bus.ISS_DIR1] = 1'b1;
    if (bus.ISS2) m_pend[bus.ISS_DIR2] = 1'b1;
    m_pend[0] = 1'b0;
  endtask

  task automatic check_all();
    logic exp_stall;
    exp_stall = m_waits(bus.RA1) || m_waits(bus.RB1) || m_waits(bus.RA2) || m_waits(bus.RB2);
    chk("QA1", bus.QA1, m_read(bus.RA1));
    chk("QB1", bus.QB1, m_read(bus.RB1));
    chk("QA2", bus.QA2, m_read(bus.RA2));
    chk("QB2", bus.QB2, m_read(bus.RB2));
    chk("STALL", 32'(bus.STALL), 32'(exp_stall));
    chk("PEND", bus.PEND, m_pend);
  endtask

  // Inputs are set just after a falling edge; this checks, then commits the edge.
  task automatic cycle();
    #1 check_all();
    @(posedge reloj);
    m_update();
    @(negedge reloj);
  endtask

  task automatic idle();
    bus.REG_WR1 = 1'b1;  bus.REG_WR2 = 1'b1;
    bus.DIR_WRA1 = '0;   bus.DIR_WRA2 = '0;
    bus.DI_banco1 = '0;  bus.DI_banco2 = '0;
    bus.DO_D1 = '0;      bus.DO_D2 = '0;
    bus.MEM_SEL1 = 1'b0; bus.MEM_SEL2 = 1'b0;
    bus.ISS1 = 1'b0;     bus.ISS2 = 1'b0;
    bus.ISS_DIR1 = '0;   bus.ISS_DIR2 = '0;
    bus.RA1 = '0; bus.RB1 = '0; bus.RA2 = '0; bus.RB2 = '0;
  endtask

  initial begin
    resetM = 1'b1;
    idle();
    m_clear();
    #1;
    for (int i = 0; i < 32; i++) begin
      bus.RA1 = 5'(i);
      #0.1 chk("rst_read", bus.QA1, 32'h0);
    end
    chk("rst_pend", bus.PEND, 32'h0);
    chk("rst_stall", 32'(bus.STALL), 32'h0);
    @(negedge reloj);
    resetM = 1'b0;

    idle();
    bus.REG_WR1 = 1'b0; bus.DIR_WRA1 = 5'd0; bus.DI_banco1 = 32'hFFFF_FFFF;
    #1 chk("r0_write", bus.QA1, 32'h0);
    cycle();

    idle();
    bus.REG_WR1 = 1'b0; bus.DIR_WRA1 = 5'd5; bus.MEM_SEL1 = 1'b0;
    bus.DI_banco1 = 32'h1234_5678; bus.DO_D1 = 32'hAAAA_AAAA; bus.RA1 = 5'd5;
    #1 chk("mux_alu", bus.QA1, 32'h1234_5678);
    cycle();

    idle();
    bus.REG_WR1 = 1'b0; bus.DIR_WRA1 = 5'd6; bus.MEM_SEL1 = 1'b1;
    bus.DI_banco1 = 32'h1234_5678; bus.DO_D1 = 32'hAAAA_AAAA;
    bus.RA1 = 5'd5; bus.RB1 = 5'd6;
    #1 chk("reg5_stored", bus.QA1, 32'h1234_5678);
    chk("mux_mem", bus.QB1, 32'hAAAA_AAAA);
    cycle();

    idle();
    bus.REG_WR1 = 1'b0; bus.DIR_WRA1 = 5'd9; bus.DI_banco1 = 32'h1111_1111;
    bus.REG_WR2 = 1'b0; bus.DIR_WRA2 = 5'd9; bus.DI_banco2 = 32'h2222_2222;
    bus.RA1 = 5'd9;
    #1 chk("conflict_byp", bus.QA1, 32'h2222_2222);
    cycle();

    idle();
    bus.RA1 = 5'd9; bus.RB2 = 5'd3;
    #1 chk("conflict_store", bus.QA1, 32'h2222_2222);
    chk("reg3_zero", bus.QB2, 32'h0);
    cycle();

    idle();
    bus.REG_WR2 = 1'b0; bus.DIR_WRA2 = 5'd3; bus.DI_banco2 = 32'h0000_BEEF; bus.RB2 = 5'd3;
    #1 chk("bypass_p2", bus.QB2, 32'h0000_BEEF);
    cycle();

    idle();
    bus.ISS1 = 1'b1; bus.ISS_DIR1 = 5'd7; bus.RA2 = 5'd7;
    #1 chk("iss_no_stall", 32'(bus.STALL), 32'h0);
    cycle();

    idle();
    bus.RA2 = 5'd7;
    #1 chk("pend7_set", 32'(bus.PEND[7]), 32'h1);
    chk("stall_pend", 32'(bus.STALL), 32'h1);
    cycle();

    idle();
    bus.REG_WR1 = 1'b0; bus.DIR_WRA1 = 5'd7; bus.DI_banco1 = 32'h0000_0077; bus.RA2 = 5'd7;
    #1 chk("stall_resolved", 32'(bus.STALL), 32'h0);
    chk("resolve_byp", bus.QA2, 32'h0000_0077);
    cycle();

    idle();
    bus.RA2 = 5'd7;
    #1 chk("pend7_clear", 32'(bus.PEND[7]), 32'h0);
    cycle();

    idle();
    bus.ISS2 = 1'b1; bus.ISS_DIR2 = 5'd7;
    bus.REG_WR1 = 1'b0; bus.DIR_WRA1 = 5'd7; bus.DI_banco1 = 32'h0000_7070;
    cycle();

    idle();
    bus.RB2 = 5'd7;
    #1 chk("set_wins", 32'(bus.PEND[7]), 32'h1);
    cycle();

    // Reset pulse between edges must clear everything without a clock.
    idle();
    bus.RA1 = 5'd5; bus.RB1 = 5'd6; bus.RA2 = 5'd9; bus.RB2 = 5'd7;
    #1 chk("pre_rst_stall", 32'(bus.STALL), 32'h1);
    chk("pre_rst_r9", bus.QA2, 32'h2222_2222);
    resetM = 1'b1;
    m_clear();
    #1 chk("arst_QA1", bus.QA1, 32'h0);
    chk("arst_QB1", bus.QB1, 32'h0);
    chk("arst_QA2", bus.QA2, 32'h0);
    chk("arst_QB2", bus.QB2, 32'h0);
    chk("arst_pend", bus.PEND, 32'h0);
    chk("arst_stall", 32'(bus.STALL), 32'h0);
    resetM = 1'b0;
    cycle();

    for (int n = 0; n < 400; n++) begin
      idle();
      bus.REG_WR1   = ($urandom_range(0, 3) == 0);
      bus.REG_WR2   = ($urandom_range(0, 3) == 0);
      bus.DIR_WRA1  = 5'($urandom_range(0, 7));
      bus.DIR_WRA2  = 5'($urandom_range(0, 7));
      bus.DI_banco1 = $urandom; bus.DI_banco2 = $urandom;
      bus.DO_D1     = $urandom; bus.DO_D2     = $urandom;
      bus.MEM_SEL1  = 1'($urandom_range(0, 1));
      bus.MEM_SEL2  = 1'($urandom_range(0, 1));
      bus.ISS1      = ($urandom_range(0, 9) < 3);
      bus.ISS2      = ($urandom_range(0, 9) < 3);
      bus.ISS_DIR1  = 5'($urandom_range(0, 7));
      bus.ISS_DIR2  = 5'($urandom_range(0, 7));
      bus.RA1 = 5'($urandom_range(0, 7)); bus.RB1 = 5'($urandom_range(0, 31));
      bus.RA2 = 5'($urandom_range(0, 7)); bus.RB2 = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
